// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit combinational ALU: registers operands, waits the
// settle time, captures result/flags, owns the flag register and evaluates branch conditions.
module alu_issue_ctrl #(
  parameter int unsigned     DATA_W      = 16,
  parameter int unsigned     OP_W        = 4,
  parameter logic [OP_W-1:0] NOP_OP      = OP_W'(4'b1111),
  parameter int unsigned     EXEC_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [OP_W-1:0]   REQ_OP,
  input  logic [DATA_W-1:0] REQ_A,
  input  logic [DATA_W-1:0] REQ_B,
  input  logic              REQ_FLAG_WE,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [OP_W-1:0]   ALU_S,
  input  logic [DATA_W-1:0] ALU_RES,
  input  logic [3:0]        ALU_FLAG,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [3:0]        RSP_FLAG,
  output logic [3:0]        FLAG_REG,
  input  logic [3:0]        COND,
  output logic              COND_TRUE
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             flag_we;

  // Controller FSM; ALU_S itself carries the in-flight op until capture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_FLAG  <= '0;
      FLAG_REG  <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_S     <= NOP_OP;
      cnt       <= '0;
      flag_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            ALU_A     <= REQ_A;
            ALU_B     <= REQ_B;
            ALU_S     <= REQ_OP;
            flag_we   <= REQ_FLAG_WE;
            cnt       <= CNT_LOAD;
            REQ_READY <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            RSP_DATA  <= ALU_RES;
            RSP_FLAG  <= ALU_FLAG;
            if (flag_we && (ALU_S != NOP_OP)) begin
              FLAG_REG <= ALU_FLAG;
            end
            RSP_VALID <= 1'b1;
            ALU_S     <= NOP_OP;
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (RSP_VALID && RSP_READY) begin
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          REQ_READY <= 1'b1;
          RSP_VALID <= 1'b0;
          ALU_S     <= NOP_OP;
        end
      endcase
    end
  end

  logic s_f, z_f, c_f, v_f;
  assign {s_f, z_f, c_f, v_f} = FLAG_REG;

  // Branch condition evaluation against the architectural flags.
  always_comb begin
    COND_TRUE = 1'b0;
    case (COND)
      4'd0:  COND_TRUE = 1'b1;
      4'd1:  COND_TRUE = z_f;
      4'd2:  COND_TRUE = !z_f;
      4'd3:  COND_TRUE = c_f;
      4'd4:  COND_TRUE = !c_f;
      4'd5:  COND_TRUE = s_f;
      4'd6:  COND_TRUE = !s_f;
      4'd7:  COND_TRUE = v_f;
      4'd8:  COND_TRUE = !v_f;
      4'd9:  COND_TRUE = (s_f == v_f);
      4'd10: COND_TRUE = (s_f != v_f);
      4'd11: COND_TRUE = !z_f && (s_f == v_f);
      4'd12: COND_TRUE = z_f || (s_f != v_f);
      4'd13: COND_TRUE = c_f && !z_f;
      4'd14: COND_TRUE = !c_f || z_f;
      default: COND_TRUE = 1'b0;
    endcase
  end

endmodule
